// File: rtl/console_io.sv
// Console I/O block: decodes CPU port bus, holds stdin (RX) / stdout (TX) byte FIFOs, exit flag, irq.
// Latency: cpu_rdata is combinational; writes and FIFO moves land at the posedge; irq is registered.
// Backpressure: rx_ready drops while RX is full; tx_valid holds until tx_ready; CPU writes to a full TX drop.
//
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   io_port, cpu_wdata,
//   cpu_wvalid, cpu_rdata        CPU port bus (port number, write data/strobe, read data)
//   irq                          level interrupt = registered |(status & mask)
//   rx_valid, rx_data, rx_ready  external stdin byte stream into the RX FIFO
//   tx_valid, tx_data, tx_ready  stdout byte stream out of the TX FIFO
//   halted, exit_code            sticky end-of-program flag and last value written to port 0

module console_io_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_dat,
  input  logic                     pop,
  output logic [7:0]               head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign count    = wr_ptr - rd_ptr;
  assign head_dat = mem[rd_ptr[AW-1:0]];
endmodule

module console_io #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [8:0]  io_port,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_wvalid,
  output logic [15:0] cpu_rdata,
  output logic        irq,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halted,
  output logic [15:0] exit_code
);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);

  localparam logic [8:0] PORT_EXIT   = 9'd0;
  localparam logic [8:0] PORT_STDIN  = 9'd2;
  localparam logic [8:0] PORT_STDOUT = 9'd3;
  localparam logic [8:0] PORT_ISTAT  = 9'd4;
  localparam logic [8:0] PORT_IMASK  = 9'd5;

  logic         rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0]   rx_head;
  logic [RAW:0] rx_cnt, rx_cnt_nxt;
  logic [TAW:0] tx_cnt, tx_cnt_nxt;
  logic         rx_push, rx_pop, tx_push, tx_pop;
  logic [1:0]   mask, mask_nxt, status, status_nxt;

  assign rx_ready = !rx_full;
  assign tx_valid = !tx_empty;

  assign rx_push = rx_valid && !rx_full;
  assign rx_pop  = cpu_wvalid && (io_port == PORT_STDIN) && !rx_empty;
  assign tx_push = cpu_wvalid && (io_port == PORT_STDOUT) && !tx_full;
  assign tx_pop  = tx_valid && tx_ready;

  console_io_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (rx_push),
    .push_dat (rx_data),
    .pop      (rx_pop),
    .head_dat (rx_head),
    .full     (rx_full),
    .empty    (rx_empty),
    .count    (rx_cnt)
  );

  console_io_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (tx_push),
    .push_dat (cpu_wdata[7:0]),
    .pop      (tx_pop),
    .head_dat (tx_data),
    .full     (tx_full),
    .empty    (tx_empty),
    .count    (tx_cnt)
  );

  assign status = {!tx_full, !rx_empty};

  // irq is registered from the state this edge produces, so the occupancies
  // and mask are projected forward rather than read back from the registers.
  assign rx_cnt_nxt = rx_cnt + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
  assign tx_cnt_nxt = tx_cnt + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
  assign mask_nxt   = (cpu_wvalid && io_port == PORT_IMASK) ? cpu_wdata[1:0] : mask;
  assign status_nxt = {tx_cnt_nxt != (TAW+1)'(TX_DEPTH), rx_cnt_nxt != '0};

  always_ff @(posedge clock) begin
    if (reset) begin
      mask      <= 2'b00;
      irq       <= 1'b0;
      halted    <= 1'b0;
      exit_code <= 16'h0000;
    end else begin
      mask <= mask_nxt;
      irq  <= |(status_nxt & mask_nxt);
      if (cpu_wvalid && io_port == PORT_EXIT) begin
        halted    <= 1'b1;
        exit_code <= cpu_wdata;
      end
    end
  end

  always_comb begin
    cpu_rdata = 16'h0000;
    case (io_port)
      PORT_STDIN:  cpu_rdata = rx_empty ? 16'h8000 : {8'h00, rx_head};
      PORT_STDOUT: cpu_rdata = {15'b0, !tx_full};
      PORT_ISTAT:  cpu_rdata = {14'b0, status & mask};
      PORT_IMASK:  cpu_rdata = {14'b0, mask};
      default:     cpu_rdata = 16'h0000;
    endcase
  end
endmodule

// File: tb/tb_console_io.sv
module tb_console_io;
  logic        clock;
  logic        reset;
  logic [8:0]  io_port;
  logic [15:0] cpu_wdata;
  logic        cpu_wvalid;
  logic [15:0] cpu_rdata;
  logic        irq;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halted;
  logic [15:0] exit_code;

  int n_tests = 0;
  int n_fail  = 0;

  console_io #(.RX_DEPTH(16), .TX_DEPTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_port    (io_port),
    .cpu_wdata  (cpu_wdata),
    .cpu_wvalid (cpu_wvalid),
    .cpu_rdata  (cpu_rdata),
    .irq        (irq),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .halted     (halted),
    .exit_code  (exit_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one posedge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_write(input logic [8:0] port, input logic [15:0] data);
    io_port    = port;
    cpu_wdata  = data;
    cpu_wvalid = 1'b1;
    step();
    cpu_wvalid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [8:0] port, input logic [15:0] exp);
    io_port = port;
    #1;
    chk(tag, cpu_rdata, exp);
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    rd({tag, "_p2"}, 9'd2, 16'h8000);
    rd({tag, "_p3"}, 9'd3, 16'h0001);
    rd({tag, "_p4"}, 9'd4, 16'h0000);
    rd({tag, "_p5"}, 9'd5, 16'h0000);
    chk({tag, "_irq"},      {15'b0, irq},      16'h0000);
    chk({tag, "_rx_ready"}, {15'b0, rx_ready}, 16'h0001);
    chk({tag, "_tx_valid"}, {15'b0, tx_valid}, 16'h0000);
    chk({tag, "_halted"},   {15'b0, halted},   16'h0000);
    chk({tag, "_exit"},     exit_code,         16'h0000);
  endtask

  initial begin
    reset      = 1'b1;
    io_port    = 9'd0;
    cpu_wdata  = 16'h0000;
    cpu_wvalid = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    tx_ready   = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // 1: reset state
    check_reset_state("rst");
    rd("p0_read", 9'd0, 16'h0000);
    rd("p1_read", 9'd1, 16'h0000);

    // 2: stdin read / pop sequence; port 4 masked to 0 while RX is non-empty
    rx_push(8'h41);
    rx_push(8'h42);
    rd("rx_head_41", 9'd2, 16'h0041);
    rd("p4_mask0", 9'd4, 16'h0000);
    chk("irq_mask0", {15'b0, irq}, 16'h0000);
    cpu_write(9'd2, 16'h0000);
    rd("rx_head_42", 9'd2, 16'h0042);
    cpu_write(9'd2, 16'h0000);
    rd("rx_empty", 9'd2, 16'h8000);
    cpu_write(9'd2, 16'h0000);   // pop on empty is ignored
    rd("rx_empty_pop", 9'd2, 16'h8000);
    cpu_write(9'd1, 16'hFFFF);   // port 1 write ignored
    rd("p1_after_wr", 9'd1, 16'h0000);
    rd("p5_after_p1", 9'd5, 16'h0000);

    // 3: interrupt path
    cpu_write(9'd5, 16'hFFFD);   // only low 2 bits land -> mask=01
    rd("mask_01", 9'd5, 16'h0001);
    chk("irq_rx_idle", {15'b0, irq}, 16'h0000);
    rx_push(8'h55);
    step();
    chk("irq_rx_set", {15'b0, irq}, 16'h0001);
    rd("p4_rx", 9'd4, 16'h0001);
    cpu_write(9'd2, 16'h0000);
    step();
    chk("irq_rx_clr", {15'b0, irq}, 16'h0000);
    rd("p4_rx_clr", 9'd4, 16'h0000);
    cpu_write(9'd5, 16'h0002);
    step();
    chk("irq_tx_set", {15'b0, irq}, 16'h0001);
    rd("p4_tx", 9'd4, 16'h0002);
    cpu_write(9'd5, 16'h0000);
    step();
    chk("irq_mask_clr", {15'b0, irq}, 16'h0000);

    // 4: stdout fill with tx_ready low, overflow drop, drain in order
    for (int i = 0; i <= 16; i++) begin
      cpu_write(9'd3, 16'(i));
      if (i == 0) begin
        chk("tx_valid_first", {15'b0, tx_valid}, 16'h0001);
        chk("tx_data_first",  {8'h00, tx_data},  16'h0000);
      end
      if (i == 14) rd("p3_15th", 9'd3, 16'h0001);
      if (i == 15) rd("p3_16th", 9'd3, 16'h0000);
    end
    rd("p3_full", 9'd3, 16'h0000);
    tx_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("tx_drain_valid", {15'b0, tx_valid}, 16'h0001);
      chk("tx_drain_data",  {8'h00, tx_data},  16'(k));
      step();
    end
    chk("tx_drained", {15'b0, tx_valid}, 16'h0000);
    tx_ready = 1'b0;

    // 5: RX full, pop while offered, simultaneous push+pop at count 8
    for (int i = 0; i < 16; i++) rx_push(8'h80 + 8'(i));
    chk("rx_full_rdy", {15'b0, rx_ready}, 16'h0000);
    rx_valid   = 1'b1;
    rx_data    = 8'hAA;
    io_port    = 9'd2;
    cpu_wdata  = 16'h0000;
    cpu_wvalid = 1'b1;
    #1;
    chk("rx_full_pop_rdy", {15'b0, rx_ready}, 16'h0000);
    step();
    rx_valid   = 1'b0;
    cpu_wvalid = 1'b0;
    chk("rx_rdy_after_pop", {15'b0, rx_ready}, 16'h0001);
    rd("rx_head_81", 9'd2, 16'h0081);
    for (int i = 0; i < 7; i++) cpu_write(9'd2, 16'h0000);   // count 15 -> 8
    rd("rx_head_88", 9'd2, 16'h0088);
    rx_valid = 1'b1;
    rx_data  = 8'hBB;
    cpu_write(9'd2, 16'h0000);
    rx_valid = 1'b0;
    rd("rx_head_89", 9'd2, 16'h0089);
    for (int i = 0; i < 7; i++) rx_push(8'hC0 + 8'(i));
    chk("rx_cnt8_not_full", {15'b0, rx_ready}, 16'h0001);
    rx_push(8'hC7);
    chk("rx_cnt8_full", {15'b0, rx_ready}, 16'h0000);

    // 6: exit code, then reset with both FIFOs occupied
    cpu_write(9'd3, 16'h0077);
    cpu_write(9'd5, 16'h0003);
    cpu_write(9'd0, 16'h002A);
    chk("halted_set", {15'b0, halted}, 16'h0001);
    chk("exit_2a",    exit_code,       16'h002A);
    cpu_write(9'd0, 16'h0033);
    chk("halted_sticky", {15'b0, halted}, 16'h0001);
    chk("exit_33",       exit_code,       16'h0033);
    chk("irq_pre_rst",   {15'b0, irq},    16'h0001);
    reset      = 1'b1;
    rx_valid   = 1'b1;
    io_port    = 9'd3;
    cpu_wdata  = 16'h0099;
    cpu_wvalid = 1'b1;
    step();
    reset      = 1'b0;
    rx_valid   = 1'b0;
    cpu_wvalid = 1'b0;
    check_reset_state("rst2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
